// File: rtl/tlc.sv
// =============================================================================
// tlc : programmable traffic-light controller (optional macro TLC_DEFAULT_TIMES_EN)
// Rev 1.0
// =============================================================================
`default_nettype none

module tlc #(
  parameter real FREQ        = 0.001,
  parameter int  ADDR_WIDTH  = 3,
  parameter int  DATA_WIDTH  = 8,
  parameter int  ADDR_RED    = 0,
  parameter int  ADDR_YELLOW = 1,
  parameter int  ADDR_GREEN  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic [1:0]            state
);

  localparam int c_TPS_RAW = int'(FREQ * 1.0e6);
  localparam int c_TPS     = (c_TPS_RAW < 1) ? 1 : c_TPS_RAW;
  localparam int c_PW      = (c_TPS > 1) ? $clog2(c_TPS) : 1;
  localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(c_TPS - 1);

`ifdef TLC_DEFAULT_TIMES_EN
  localparam logic [DATA_WIDTH-1:0] c_RST_RED   = DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] c_RST_YEL   = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] c_RST_GRN   = DATA_WIDTH'(5);
  localparam logic [2:0]            c_RST_FLAGS = 3'b111;
`else
  localparam logic [DATA_WIDTH-1:0] c_RST_RED   = '0;
  localparam logic [DATA_WIDTH-1:0] c_RST_YEL   = '0;
  localparam logic [DATA_WIDTH-1:0] c_RST_GRN   = '0;
  localparam logic [2:0]            c_RST_FLAGS = 3'b000;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RED    = 2'd1,
    S_YELLOW = 2'd2,
    S_GREEN  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_red;
  logic [DATA_WIDTH-1:0] r_yel;
  logic [DATA_WIDTH-1:0] r_grn;
  logic [2:0]            r_flags;   // {green, yellow, red}
  logic [DATA_WIDTH-1:0] r_sec;
  logic [c_PW-1:0]       r_pre;

  logic                  w_wr;
  logic                  w_wr_red;
  logic                  w_wr_yel;
  logic                  w_wr_grn;
  logic [DATA_WIDTH-1:0] w_red_cur;
  logic [DATA_WIDTH-1:0] w_yel_cur;
  logic [DATA_WIDTH-1:0] w_grn_cur;
  logic                  w_wrap;
  logic                  w_done;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_load_val;

  assign ready    = 1'b1;
  assign state    = r_state;

  assign w_wr     = valid && ready;
  assign w_wr_red = w_wr && (addr == ADDR_WIDTH'(ADDR_RED));
  assign w_wr_yel = w_wr && (addr == ADDR_WIDTH'(ADDR_YELLOW));
  assign w_wr_grn = w_wr && (addr == ADDR_WIDTH'(ADDR_GREEN));

  // A write landing on the same edge a phase is entered must win over the old value.
  assign w_red_cur = w_wr_red ? data : r_red;
  assign w_yel_cur = w_wr_yel ? data : r_yel;
  assign w_grn_cur = w_wr_grn ? data : r_grn;

  assign w_wrap = (r_pre == c_PRE_MAX);
  assign w_done = w_wrap && (r_sec <= DATA_WIDTH'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_red   <= c_RST_RED;
      r_yel   <= c_RST_YEL;
      r_grn   <= c_RST_GRN;
      r_flags <= c_RST_FLAGS;
    end else begin
      if (w_wr_red) begin
        r_red      <= data;
        r_flags[0] <= 1'b1;
      end
      if (w_wr_yel) begin
        r_yel      <= data;
        r_flags[1] <= 1'b1;
      end
      if (w_wr_grn) begin
        r_grn      <= data;
        r_flags[2] <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    case (r_state)
      S_IDLE: begin
        if (&r_flags) begin
          w_state_nxt = S_RED;
          w_load      = 1'b1;
          w_load_val  = w_red_cur;
        end
      end
      S_RED: begin
        if (w_done) begin
          w_state_nxt = S_GREEN;
          w_load      = 1'b1;
          w_load_val  = w_grn_cur;
        end
      end
      S_GREEN: begin
        if (w_done) begin
          w_state_nxt = S_YELLOW;
          w_load      = 1'b1;
          w_load_val  = w_yel_cur;
        end
      end
      S_YELLOW: begin
        if (w_done) begin
          w_state_nxt = S_RED;
          w_load      = 1'b1;
          w_load_val  = w_red_cur;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Phase ends on the wrap that would take the second counter to zero, giving duration*TPS cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_sec   <= '0;
      r_pre   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_sec <= (w_load_val == '0) ? DATA_WIDTH'(1) : w_load_val;
        r_pre <= '0;
      end else if (r_state != S_IDLE) begin
        if (w_wrap) begin
          r_pre <= '0;
          r_sec <= r_sec - DATA_WIDTH'(1);
        end else begin
          r_pre <= r_pre + c_PW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tlc.sv
// =============================================================================
// tb_tlc : table-driven bench with a phase-length scoreboard for tlc (FREQ=0.001, TPS=1000)
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_tlc;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] data = '0;
  logic       valid = 1'b0;
  logic       ready;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] st;
    int         len;
    string      name;
  } seg_t;

  typedef struct {
    logic [7:0] red;
    logic [7:0] yel;
    logic [7:0] grn;
    int         red_len;
    int         grn_len;
    int         yel_len;
  } vec_t;

  seg_t sb[$];
  vec_t tbl[3];

  tlc #(
    .FREQ        (0.001),
    .ADDR_WIDTH  (3),
    .DATA_WIDTH  (8),
    .ADDR_RED    (0),
    .ADDR_YELLOW (1),
    .ADDR_GREEN  (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .state (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_one(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    addr  = a;
    data  = d;
    valid = 1'b1;
  endtask

  // Ends one negedge after the last accepted write; checks the block is idle there and RED on the next edge.
  task automatic finish_prog(input string tag);
    @(negedge clk);
    valid = 1'b0;
    chk({tag, "_idle_before_start"}, int'(state), 0);
    @(negedge clk);
    chk({tag, "_red_on_next_edge"}, int'(state), 1);
  endtask

  task automatic prog(input string tag, input logic [7:0] r, input logic [7:0] y, input logic [7:0] g);
    write_one(3'd0, r);
    write_one(3'd1, y);
    write_one(3'd2, g);
    finish_prog(tag);
  endtask

  task automatic push_seg(input logic [1:0] st, input int len, input string name);
    seg_t s;
    s.st   = st;
    s.len  = len;
    s.name = name;
    sb.push_back(s);
  endtask

  // Pops expected phases; each measurement starts on the first negedge of that phase.
  task automatic run_sb();
    while (sb.size() > 0) begin
      seg_t s;
      int   cnt;
      s   = sb.pop_front();
      cnt = 0;
      while (state == s.st && cnt < s.len + 20) begin
        cnt++;
        @(negedge clk);
      end
      chk(s.name, cnt, s.len);
    end
  endtask

  initial begin
    int bad;

    tbl[0] = '{red: 8'd3, yel: 8'd1, grn: 8'd5, red_len: 3000, grn_len: 5000, yel_len: 1000};
    tbl[1] = '{red: 8'd0, yel: 8'd1, grn: 8'd1, red_len: 1000, grn_len: 1000, yel_len: 1000};
    tbl[2] = '{red: 8'd2, yel: 8'd3, grn: 8'd1, red_len: 2000, grn_len: 1000, yel_len: 3000};

    // Reset values
    repeat (2) @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_ready", int'(ready), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", int'(ready), 1);

    // Table: program, then check RED, GREEN, YELLOW and the following RED
    for (int i = 0; i < 3; i++) begin
      do_reset();
      prog($sformatf("vec%0d", i), tbl[i].red, tbl[i].yel, tbl[i].grn);
      chk($sformatf("vec%0d_ready", i), int'(ready), 1);
      push_seg(2'd1, tbl[i].red_len, $sformatf("vec%0d_red_len", i));
      push_seg(2'd3, tbl[i].grn_len, $sformatf("vec%0d_green_len", i));
      push_seg(2'd2, tbl[i].yel_len, $sformatf("vec%0d_yellow_len", i));
      push_seg(2'd1, tbl[i].red_len, $sformatf("vec%0d_red2_len", i));
      run_sb();
    end

    // Reset mid-GREEN, stays idle after release, then reprogram 4,2,7
    do_reset();
    prog("rstmid", 8'd1, 8'd1, 8'd1);
    push_seg(2'd1, 1000, "rstmid_red_len");
    run_sb();
    repeat (500) @(negedge clk);
    chk("rstmid_in_green", int'(state), 3);
    rst = 1'b0;
    #1;
    chk("rstmid_async_idle", int'(state), 0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (state != 2'd0) bad++;
    end
    chk("rstmid_hold_nonidle_cycles", bad, 0);
    rst = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (state != 2'd0) bad++;
    end
    chk("rstmid_after_release_nonidle_cycles", bad, 0);
    prog("reprog", 8'd4, 8'd2, 8'd7);
    push_seg(2'd1, 4000, "reprog_red_len");
    push_seg(2'd3, 7000, "reprog_green_len");
    push_seg(2'd2, 2000, "reprog_yellow_len");
    run_sb();

    // Partial programming plus writes to unmapped addresses must not start the block
    do_reset();
    write_one(3'd0, 8'd2);
    write_one(3'd2, 8'd1);
    write_one(3'd3, 8'd9);
    write_one(3'd7, 8'd9);
    @(negedge clk);
    valid = 1'b0;
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (state != 2'd0) bad++;
    end
    chk("partial_nonidle_cycles", bad, 0);
    write_one(3'd1, 8'd1);
    finish_prog("partial");
    push_seg(2'd1, 2000, "partial_red_len");
    push_seg(2'd3, 1000, "partial_green_len");
    push_seg(2'd2, 1000, "partial_yellow_len");
    run_sb();

    // Write green=2 during RED: RED keeps 3000 (two RED cycles already spent here), GREEN becomes 2000
    do_reset();
    prog("runwr", 8'd3, 8'd1, 8'd5);
    write_one(3'd2, 8'd2);
    @(negedge clk);
    valid = 1'b0;
    push_seg(2'd1, 2998, "runwr_red_rest_len");
    push_seg(2'd3, 2000, "runwr_green_len");
    push_seg(2'd2, 1000, "runwr_yellow_len");
    run_sb();

    // Write green=3 on the very edge GREEN is entered: new value applies
    do_reset();
    prog("edgewr", 8'd1, 8'd1, 8'd1);
    repeat (999) @(negedge clk);
    chk("edgewr_last_red_cycle", int'(state), 1);
    addr  = 3'd2;
    data  = 8'd3;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    push_seg(2'd3, 3000, "edgewr_green_len");
    push_seg(2'd2, 1000, "edgewr_yellow_len");
    run_sb();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
